// File: rtl/data_sram_bridge.sv
// rtl/data_sram_bridge.sv - CPU data port to async 32-bit SRAM bridge with wait states and pipeline stall.
// Optional upper-address range check enabled by SRAM_BRIDGE_ADDR_CHECK_EN (adds addr_err).
module data_sram_bridge #(
    parameter int ADDR_W      = 20,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ram_enabler,
    input  logic              ram_write_en,
    input  logic [3:0]        ram_select,
    input  logic [31:0]       ram_addr,
    input  logic [31:0]       ram_wdata,
    output logic [31:0]       ram_rdata,
    output logic              stall_req,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_dq_o,
    output logic              sram_dq_oe,
    input  logic [31:0]       sram_dq_i,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [3:0]        sram_be_n
`ifdef SRAM_BRIDGE_ADDR_CHECK_EN
    ,
    output logic              addr_err
`endif
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state;
    state_t      stateNext;
    logic [3:0]  cnt;
    logic        writeFlag;
    logic        addrBad;
    logic        addrOutOfRange;
    logic        lastCycle;
    logic        startReq;
    logic [31:0] laneMask;
    logic        unusedAddr;

`ifdef SRAM_BRIDGE_ADDR_CHECK_EN
    assign addrOutOfRange = |(ram_addr >> (ADDR_W + 2));
    assign addr_err       = ~rst & (state == DONE) & addrBad;
`else
    assign addrOutOfRange = 1'b0;
`endif

    // Byte-offset bits and any aliased upper bits carry no information for a word SRAM.
    assign unusedAddr = ^{ram_addr[1:0], ram_addr[31:ADDR_W+2]};

    assign lastCycle = (cnt == 4'(WAIT_CYCLES));
    assign startReq  = (state == IDLE) & ram_enabler;
    assign laneMask  = {{8{~sram_be_n[3]}}, {8{~sram_be_n[2]}},
                        {8{~sram_be_n[1]}}, {8{~sram_be_n[0]}}};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (ram_enabler) stateNext = ACCESS;
            ACCESS:  if (lastCycle) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= 4'd0;
            ram_rdata <= 32'd0;
            sram_addr <= '0;
            sram_dq_o <= 32'd0;
            sram_be_n <= 4'hF;
            writeFlag <= 1'b0;
            addrBad   <= 1'b0;
        end else if (startReq) begin
            cnt       <= 4'd0;
            sram_addr <= ram_addr[ADDR_W+1:2];
            sram_dq_o <= ram_wdata;
            sram_be_n <= ~ram_select;
            writeFlag <= ram_write_en;
            addrBad   <= addrOutOfRange;
        end else if (state == ACCESS) begin
            cnt <= cnt + 4'd1;
            if (lastCycle && !writeFlag) begin
                ram_rdata <= addrBad ? 32'd0 : (sram_dq_i & laneMask);
            end
        end
    end

    // Strobes decode straight from state so a reset drops them before the next edge.
    always_comb begin
        stall_req  = 1'b0;
        sram_ce_n  = 1'b1;
        sram_oe_n  = 1'b1;
        sram_we_n  = 1'b1;
        sram_dq_oe = 1'b0;
        if (!rst) begin
            case (state)
                IDLE:   stall_req = ram_enabler;
                ACCESS: begin
                    stall_req = 1'b1;
                    if (!addrBad) begin
                        sram_ce_n = 1'b0;
                        if (writeFlag) begin
                            sram_dq_oe = 1'b1;
                            sram_we_n  = ~((cnt >= 4'd1) && (cnt <= 4'(WAIT_CYCLES - 1)));
                        end else begin
                            sram_oe_n = 1'b0;
                        end
                    end
                end
                default: stall_req = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_data_sram_bridge.sv
// tb/tb_data_sram_bridge.sv - directed self-checking bench for data_sram_bridge with a byte-lane SRAM model.
module tb_data_sram_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        ram_enabler, en5, ram_write_en;
    logic [3:0]  ram_select;
    logic [31:0] ram_addr, ram_wdata;

    logic [31:0] ram_rdata, sram_dq_o, sram_dq_i;
    logic        stall_req, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
    logic [19:0] sram_addr;
    logic [3:0]  sram_be_n;

    logic [31:0] rdataB, dqoB, dqiB;
    logic        stallB, dqoeB, ceB, oeB, weB;
    logic [19:0] addrB;
    logic [3:0]  beB;
`ifdef SRAM_BRIDGE_ADDR_CHECK_EN
    logic        addr_err, addrErrB;
`endif

    logic [31:0] mem [0:15];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    data_sram_bridge #(.ADDR_W(20), .WAIT_CYCLES(2)) dutA (
        .clk(clk), .rst(rst), .ram_enabler(ram_enabler), .ram_write_en(ram_write_en),
        .ram_select(ram_select), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .stall_req(stall_req), .sram_addr(sram_addr),
        .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .sram_be_n(sram_be_n)
`ifdef SRAM_BRIDGE_ADDR_CHECK_EN
        , .addr_err(addr_err)
`endif
    );

    data_sram_bridge #(.ADDR_W(20), .WAIT_CYCLES(5)) dutB (
        .clk(clk), .rst(rst), .ram_enabler(en5), .ram_write_en(ram_write_en),
        .ram_select(ram_select), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(rdataB), .stall_req(stallB), .sram_addr(addrB),
        .sram_dq_o(dqoB), .sram_dq_oe(dqoeB), .sram_dq_i(dqiB),
        .sram_ce_n(ceB), .sram_oe_n(oeB), .sram_we_n(weB), .sram_be_n(beB)
`ifdef SRAM_BRIDGE_ADDR_CHECK_EN
        , .addr_err(addrErrB)
`endif
    );

    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[3:0]] : 32'hFFFF_FFFF;
    assign dqiB      = (!ceB && !oeB) ? 32'h1234_5678 : 32'hFFFF_FFFF;

    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
            for (int i = 0; i < 4; i++) begin
                if (!sram_be_n[i]) mem[sram_addr[3:0]][8*i +: 8] <= sram_dq_o[8*i +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the DONE cycle.
    task automatic doAccess(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [3:0] sel, output int stallCyc, output int weCyc,
                            output int oeCyc, output int ceCyc, output logic [31:0] rd,
                            output logic [19:0] sa, output logic [3:0] be);
        ram_enabler = 1'b1; ram_write_en = we; ram_addr = addr; ram_wdata = wd; ram_select = sel;
        stallCyc = 0; weCyc = 0; oeCyc = 0; ceCyc = 0; sa = '1; be = 4'hF;
        #1;
        for (int i = 0; i < 40; i++) begin
            if (!stall_req) break;
            stallCyc++;
            if (!sram_we_n) weCyc++;
            if (!sram_oe_n) oeCyc++;
            if (!sram_ce_n) begin
                ceCyc++; sa = sram_addr; be = sram_be_n;
            end
            @(posedge clk); @(negedge clk); #1;
        end
        chk("done_stall_low", {31'd0, stall_req}, 32'd0);
        rd = ram_rdata;
    endtask

    task automatic toIdle();
        ram_enabler = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    int          sc, wc, oc, cc;
    logic [31:0] rd;
    logic [19:0] sa;
    logic [3:0]  be;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'd0;
        mem[0] = 32'h0BAD_F00D;
        mem[4] = 32'hDEAD_BEEF;
        mem[6] = 32'h6666_6666;
        rst = 1'b1; ram_enabler = 1'b1; en5 = 1'b0; ram_write_en = 1'b0;
        ram_select = 4'h0; ram_addr = 32'd0; ram_wdata = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_rdata", ram_rdata, 32'd0);
        chk("rst_strobes", {28'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 32'hE);
        chk("rst_be", {28'd0, sram_be_n}, 32'hF);
        chk("rst_addr", {12'd0, sram_addr}, 32'd0);
        chk("rst_dqo", sram_dq_o, 32'd0);
        chk("rst_stall", {31'd0, stall_req}, 32'd0);
        ram_enabler = 1'b0; rst = 1'b0;
        @(posedge clk); @(negedge clk);

        doAccess(1'b0, 32'h0000_0010, 32'd0, 4'hF, sc, wc, oc, cc, rd, sa, be);
        chk("t1_stall", sc, 4);
        chk("t1_oe", oc, 3);
        chk("t1_ce", cc, 3);
        chk("t1_we", wc, 0);
        chk("t1_addr", {12'd0, sa}, 32'd4);
        chk("t1_rdata", rd, 32'hDEAD_BEEF);
        toIdle();

        doAccess(1'b1, 32'h0000_0008, 32'h1122_3344, 4'b0100, sc, wc, oc, cc, rd, sa, be);
        chk("t2_be", {28'd0, be}, 32'hB);
        chk("t2_we", wc, 1);
        chk("t2_oe", oc, 0);
        chk("t2_stall", sc, 4);
        chk("t2_rdata_kept", rd, 32'hDEAD_BEEF);
        toIdle();
        chk("t2_mem", mem[2], 32'h0022_0000);
        doAccess(1'b0, 32'h0000_0008, 32'd0, 4'hF, sc, wc, oc, cc, rd, sa, be);
        chk("t2_readback", rd, 32'h0022_0000);
        toIdle();

        doAccess(1'b1, 32'h0000_000C, 32'hA5A5_A5A5, 4'hF, sc, wc, oc, cc, rd, sa, be);
        chk("t3_wr_stall", sc, 4);
        ram_write_en = 1'b0;
        @(posedge clk); @(negedge clk);
        doAccess(1'b0, 32'h0000_000C, 32'd0, 4'hF, sc, wc, oc, cc, rd, sa, be);
        chk("t3_rd_stall", sc, 4);
        chk("t3_rdata", rd, 32'hA5A5_A5A5);
        toIdle();

        ram_enabler = 1'b1; ram_write_en = 1'b1; ram_addr = 32'h18;
        ram_wdata = 32'hFFFF_0000; ram_select = 4'hF;
        @(posedge clk); @(negedge clk);
        ram_enabler = 1'b0;
        @(posedge clk); @(negedge clk); #1;
        chk("t4_we_at_cnt1", {31'd0, sram_we_n}, 32'd0);
        rst = 1'b1; #1;
        chk("t4_stall_in_rst", {31'd0, stall_req}, 32'd0);
        @(posedge clk); @(negedge clk); #1;
        chk("t4_strobes", {28'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 32'hE);
        chk("t4_stall_rst_held", {31'd0, stall_req}, 32'd0);
        rst = 1'b0;
        @(posedge clk); @(negedge clk); #1;
        chk("t4_idle", {31'd0, stall_req}, 32'd0);
        chk("t4_mem", mem[6], 32'h6666_6666);
        doAccess(1'b0, 32'h0000_0018, 32'd0, 4'hF, sc, wc, oc, cc, rd, sa, be);
        chk("t4_readback", rd, 32'h6666_6666);

`ifdef SRAM_BRIDGE_ADDR_CHECK_EN
        chk("t6_err_idle", {31'd0, addr_err}, 32'd0);
        toIdle();
        doAccess(1'b0, 32'h8000_0000, 32'd0, 4'hF, sc, wc, oc, cc, rd, sa, be);
        chk("t6_ce", cc, 0);
        chk("t6_rdata", rd, 32'd0);
        chk("t6_err_done", {31'd0, addr_err}, 32'd1);
        toIdle(); #1;
        chk("t6_err_after", {31'd0, addr_err}, 32'd0);
`else
        toIdle();
        doAccess(1'b0, 32'h8000_0000, 32'd0, 4'hF, sc, wc, oc, cc, rd, sa, be);
        chk("t6_ce", cc, 3);
        chk("t6_addr", {12'd0, sa}, 32'd0);
        chk("t6_rdata", rd, 32'h0BAD_F00D);
        toIdle();
`endif

        en5 = 1'b1; ram_write_en = 1'b0; ram_addr = 32'h20; ram_select = 4'hF;
        sc = 0; oc = 0;
        #1;
        for (int i = 0; i < 40; i++) begin
            if (!stallB) break;
            sc++;
            if (!oeB) oc++;
            @(posedge clk); @(negedge clk); #1;
        end
        chk("t5_stall", sc, 7);
        chk("t5_oe", oc, 6);
        chk("t5_rdata", rdataB, 32'h1234_5678);
        en5 = 1'b0;
        @(posedge clk); @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
